// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the fetch/data SRAM port arbiter: FSM states,
// access sizes and transaction owner.
package sram_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access:
// one outstanding transaction, round-robin on conflict, flushed fetches dropped.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [1:0]          m_size,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  logic [1:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                discard_q, discard_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic inst_cand;
  logic inst_dead;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    discard_d    = discard_q;
    wr_d         = wr_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m_req        = 1'b0;
    i_addr_ok    = 1'b0;
    d_addr_ok    = 1'b0;
    i_data_ok    = 1'b0;
    d_data_ok    = 1'b0;
    // A flush in the current cycle kills the fetch just as a stored discard does.
    inst_cand    = i_req & ~flush;
    inst_dead    = discard_q | flush;

    case (state_q)
      ST_IDLE: begin
        if (d_req && (!inst_cand || last_grant_q == OWNER_INST)) begin
          owner_d      = OWNER_DATA;
          last_grant_d = OWNER_DATA;
          wr_d         = d_wr;
          size_d       = d_size;
          wstrb_d      = d_wstrb;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          state_d      = ST_ADDR;
        end else if (inst_cand) begin
          owner_d      = OWNER_INST;
          last_grant_d = OWNER_INST;
          wr_d         = 1'b0;
          size_d       = SIZE_WORD;
          wstrb_d      = '0;
          addr_d       = i_addr;
          wdata_d      = '0;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_req = 1'b1;
        if (owner_q == OWNER_DATA) begin
          d_addr_ok = m_addr_ok;
        end else begin
          i_addr_ok = m_addr_ok & ~inst_dead;
          if (flush) discard_d = 1'b1;
        end
        if (m_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (owner_q == OWNER_DATA) begin
          d_data_ok = m_data_ok;
        end else begin
          i_data_ok = m_data_ok & ~inst_dead;
          if (flush) discard_d = 1'b1;
        end
        if (m_data_ok) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_INST;
      last_grant_q <= OWNER_INST;
      discard_q    <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= '0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      discard_q    <= discard_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign m_wr    = wr_q;
  assign m_size  = size_q;
  assign m_wstrb = wstrb_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter: one task per scenario,
// inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; i_req = 0; i_addr = 0;
    d_req = 0; d_wr = 0; d_size = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    step();
    step();
    rst = 0;
    step();
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    step();
    @(negedge clk);
    checks++;
    if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, m_wr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, m_wr});
    end
    checks++;
    if ({m_size, m_wstrb, m_addr, m_wdata} !== 70'b0) begin
      errors++;
      $display("FAIL reset_payload: size=%0d wstrb=%h addr=%h wdata=%h want all 0",
               m_size, m_wstrb, m_addr, m_wdata);
    end
    step();
    rst = 0;
    step();
  endtask

  task automatic test_inst_read();
    i_req = 1; i_addr = 32'h1C000000;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0) begin errors++; $display("FAIL ird_idle_mreq: got %b want 0", m_req); end
    step();
    m_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({m_req, m_wr, m_size, m_wstrb, m_addr} !== {1'b1, 1'b0, 2'd2, 4'h0, 32'h1C000000}) begin
      errors++;
      $display("FAIL ird_mport: req=%b wr=%b size=%0d wstrb=%h addr=%h want 1 0 2 0 1c000000",
               m_req, m_wr, m_size, m_wstrb, m_addr);
    end
    checks++;
    if ({i_addr_ok, d_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL ird_addr_ok: i=%b d=%b want 1 0", i_addr_ok, d_addr_ok);
    end
    step();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h02800000;
    @(negedge clk);
    checks++;
    if ({i_data_ok, d_data_ok, m_req, i_rdata} !== {3'b100, 32'h02800000}) begin
      errors++;
      $display("FAIL ird_data: i_ok=%b d_ok=%b m_req=%b rdata=%h want 1 0 0 02800000",
               i_data_ok, d_data_ok, m_req, i_rdata);
    end
    step();
    m_data_ok = 0;
    @(negedge clk);
    checks++;
    if ({i_data_ok, m_req} !== 2'b00) begin
      errors++; $display("FAIL ird_after: i_ok=%b m_req=%b want 0 0", i_data_ok, m_req);
    end
  endtask

  task automatic test_data_write();
    d_req = 1; d_wr = 1; d_size = 2; d_wstrb = 4'hF; d_addr = 32'h8000; d_wdata = 32'hDEADBEEF;
    step();
    m_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata} !==
        {1'b1, 1'b1, 2'd2, 4'hF, 32'h8000, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL dwr_mport: req=%b wr=%b size=%0d wstrb=%h addr=%h wdata=%h want 1 1 2 f 8000 deadbeef",
               m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata);
    end
    checks++;
    if ({d_addr_ok, i_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL dwr_addr_ok: d=%b i=%b want 1 0", d_addr_ok, i_addr_ok);
    end
    step();
    d_req = 0; d_wr = 0; m_addr_ok = 0;
    @(negedge clk);
    checks++;
    if ({d_data_ok, m_req} !== 2'b00) begin
      errors++; $display("FAIL dwr_wait: d_ok=%b m_req=%b want 0 0", d_data_ok, m_req);
    end
    step();
    m_data_ok = 1;
    @(negedge clk);
    checks++;
    if ({d_data_ok, i_data_ok} !== 2'b10) begin
      errors++; $display("FAIL dwr_done: d_ok=%b i_ok=%b want 1 0", d_data_ok, i_data_ok);
    end
    step();
    m_data_ok = 0;
    @(negedge clk);
    checks++;
    if ({d_data_ok, m_req} !== 2'b00) begin
      errors++; $display("FAIL dwr_once: d_ok=%b m_req=%b want 0 0", d_data_ok, m_req);
    end
  endtask

  task automatic test_round_robin();
    logic exp_data;
    do_reset();
    i_req = 1; i_addr = 32'h1C000040;
    d_req = 1; d_wr = 0; d_size = 2; d_wstrb = 0; d_addr = 32'h9000; d_wdata = 0;
    for (int t = 0; t < 4; t++) begin
      exp_data = (t % 2 == 0);
      step();
      m_addr_ok = 1;
      @(negedge clk);
      checks++;
      if ({d_addr_ok, i_addr_ok} !== {exp_data, ~exp_data} ||
          m_addr !== (exp_data ? 32'h9000 : 32'h1C000040)) begin
        errors++;
        $display("FAIL rr_grant%0d: d_ok=%b i_ok=%b addr=%h want data=%b", t,
                 d_addr_ok, i_addr_ok, m_addr, exp_data);
      end
      step();
      m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hA0 + 32'(t);
      @(negedge clk);
      checks++;
      if ({d_data_ok, i_data_ok} !== {exp_data, ~exp_data}) begin
        errors++;
        $display("FAIL rr_data%0d: d_ok=%b i_ok=%b want data=%b", t, d_data_ok, i_data_ok, exp_data);
      end
      step();
      m_data_ok = 0;
    end
    i_req = 0; d_req = 0;
    step();
  endtask

  task automatic test_flush_in_data();
    i_req = 1; i_addr = 32'h1C000200;
    step();
    m_addr_ok = 1;
    step();
    i_req = 0; m_addr_ok = 0; flush = 1;
    @(negedge clk);
    checks++;
    if (i_data_ok !== 1'b0) begin errors++; $display("FAIL fdata_flush: i_ok=%b want 0", i_data_ok); end
    step();
    flush = 0; m_data_ok = 1; m_rdata = 32'h1234;
    @(negedge clk);
    checks++;
    if (i_data_ok !== 1'b0) begin errors++; $display("FAIL fdata_drop: i_ok=%b want 0", i_data_ok); end
    step();
    m_data_ok = 0; i_req = 1; i_addr = 32'h1C008000;
    step();
    m_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({i_addr_ok, m_addr} !== {1'b1, 32'h1C008000}) begin
      errors++; $display("FAIL fdata_newpc: i_addr_ok=%b addr=%h want 1 1c008000", i_addr_ok, m_addr);
    end
    step();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h55AA55AA;
    @(negedge clk);
    checks++;
    if ({i_data_ok, i_rdata} !== {1'b1, 32'h55AA55AA}) begin
      errors++; $display("FAIL fdata_newpc_data: i_ok=%b rdata=%h want 1 55aa55aa", i_data_ok, i_rdata);
    end
    step();
    m_data_ok = 0;
  endtask

  task automatic test_flush_in_addr();
    logic saw_req_drop;
    logic saw_addr_ok;
    saw_req_drop = 0; saw_addr_ok = 0;
    i_req = 1; i_addr = 32'h1C000300;
    step();
    flush = 1; i_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (m_req !== 1'b1) saw_req_drop = 1;
      if (i_addr_ok !== 1'b0) saw_addr_ok = 1;
      step();
      flush = 0;
    end
    m_addr_ok = 1;
    @(negedge clk);
    if (m_req !== 1'b1) saw_req_drop = 1;
    if (i_addr_ok !== 1'b0) saw_addr_ok = 1;
    checks++;
    if (saw_req_drop) begin errors++; $display("FAIL faddr_hold: m_req dropped=1 want 0"); end
    checks++;
    if (saw_addr_ok) begin errors++; $display("FAIL faddr_addr_ok: i_addr_ok pulsed=1 want 0"); end
    step();
    m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hCAFE0000;
    @(negedge clk);
    checks++;
    if (i_data_ok !== 1'b0) begin errors++; $display("FAIL faddr_drop: i_ok=%b want 0", i_data_ok); end
    step();
    m_data_ok = 0;
  endtask

  task automatic test_flush_corners();
    // flush in IDLE masks i_req
    i_req = 1; i_addr = 32'h1C000400; flush = 1;
    step();
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0) begin errors++; $display("FAIL fidle_mask: m_req=%b want 0", m_req); end
    flush = 0;
    step();
    m_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({m_req, i_addr_ok, m_addr} !== {2'b11, 32'h1C000400}) begin
      errors++; $display("FAIL fidle_grant: m_req=%b i_ok=%b addr=%h want 1 1 1c000400", m_req, i_addr_ok, m_addr);
    end
    step();
    // flush coincident with response drops it
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; flush = 1;
    @(negedge clk);
    checks++;
    if (i_data_ok !== 1'b0) begin errors++; $display("FAIL fsame_drop: i_ok=%b want 0", i_data_ok); end
    step();
    m_data_ok = 0; flush = 0;
    // flush has no effect on a data transaction
    d_req = 1; d_wr = 0; d_size = 0; d_wstrb = 0; d_addr = 32'h8004;
    step();
    flush = 1; m_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({d_addr_ok, m_size} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL fdata_owner_addr: d_ok=%b size=%0d want 1 0", d_addr_ok, m_size);
    end
    step();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h000000EE;
    @(negedge clk);
    checks++;
    if ({d_data_ok, d_rdata} !== {1'b1, 32'h000000EE}) begin
      errors++; $display("FAIL fdata_owner_data: d_ok=%b rdata=%h want 1 000000ee", d_data_ok, d_rdata);
    end
    step();
    m_data_ok = 0; flush = 0;
  endtask

  task automatic test_reset_mid();
    i_req = 1; i_addr = 32'h1C000500;
    step();
    m_addr_ok = 1;
    step();
    i_req = 0; m_addr_ok = 0;
    m_data_ok = 1; rst = 1;
    #1;
    checks++;
    if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, m_wr, m_size, m_wstrb, m_addr, m_wdata} !== 76'b0) begin
      errors++;
      $display("FAIL rmid_outputs: req=%b i_ok=%b d_ok=%b i_dok=%b d_dok=%b addr=%h want all 0",
               m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, m_addr);
    end
    step();
    rst = 0; m_data_ok = 0;
    step();
    i_req = 1; i_addr = 32'h1C000600;
    step();
    m_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({m_req, i_addr_ok, m_addr} !== {2'b11, 32'h1C000600}) begin
      errors++; $display("FAIL rmid_post_addr: m_req=%b i_ok=%b addr=%h want 1 1 1c000600", m_req, i_addr_ok, m_addr);
    end
    step();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h00C0FFEE;
    @(negedge clk);
    checks++;
    if ({i_data_ok, i_rdata} !== {1'b1, 32'h00C0FFEE}) begin
      errors++; $display("FAIL rmid_post_data: i_ok=%b rdata=%h want 1 00c0ffee", i_data_ok, i_rdata);
    end
    step();
    m_data_ok = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_inst_read();
    test_data_write();
    test_round_robin();
    test_flush_in_data();
    test_flush_in_addr();
    test_flush_corners();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (MEM-stage) requester.
- Sits between the fetch/memory stages and the SRAM-to-AXI bridge.
- Serialises transactions with at most one outstanding, uses round-robin on conflict, and discards fetch responses cancelled by exception/ertn flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  exception or ertn redirect; cancels the in-flight fetch
i_req  in  1  fetch request; held until i_addr_ok
i_addr  in  ADDR_W  fetch address
i_addr_ok  out  1  fetch request accepted
i_data_ok  out  1  fetch data valid
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held until d_addr_ok
d_wr  in  1  1 = write
d_size  in  2  0 = byte, 1 = half, 2 = word
d_wstrb  in  DATA_W/8  write byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_addr_ok  out  1  data request accepted
d_data_ok  out  1  read data valid or write done
d_rdata  out  DATA_W  data read data
m_req  out  1  memory-port request
m_wr  out  1  memory-port write
m_size  out  2  memory-port size
m_wstrb  out  DATA_W/8  memory-port byte enables
m_addr  out  ADDR_W  memory-port address
m_wdata  out  DATA_W  memory-port write data
m_addr_ok  in  1  memory port accepted request
m_data_ok  in  1  memory port response
m_rdata  in  DATA_W  memory-port read data

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Registered state:
  - owner (0 = inst, 1 = data)
  - last_grant
  - discard
  - payload latch: wr, size, wstrb, addr, wdata
- While rst is high, and as reset values:
  - state = IDLE, owner = 0, last_grant = 0, discard = 0, payload latch = 0.
  - m_req, i_addr_ok, d_addr_ok, i_data_ok and d_data_ok are all 0.
  - m_wr, m_size, m_wstrb, m_addr and m_wdata are 0.
- IDLE:
  - Only d_req: grant data.
  - Only i_req: grant inst.
  - Both requests: grant the requester not equal to last_grant.
  - On grant: latch owner and payload. An inst grant latches wr = 0, size = 2 and wstrb = 0. Set last_grant = owner, then go to ADDR.
  - If flush is high in IDLE, i_req is ignored that cycle.
- ADDR:
  - m_req = 1, driven from the latched payload.
  - On m_addr_ok, go to DATA.
  - The owner's addr_ok = m_addr_ok in the same cycle, combinational.
  - Exception: when owner = inst and discard (or flush) is set, i_addr_ok is suppressed.
- DATA:
  - m_req = 0.
  - On m_data_ok: the owner's data_ok = 1 and its rdata = m_rdata, same cycle, combinational. Then go to IDLE and clear discard.
  - If owner = inst and discard = 1, i_data_ok stays 0 (response dropped).
- Flush rules:
  - flush in ADDR or DATA with owner = inst sets discard.
  - In ADDR, m_req stays asserted until m_addr_ok; a request is never withdrawn.
  - flush has no effect on a data-owned transaction.
- Latency:
  - Request seen at cycle N gives m_req at N+1; earliest addr_ok is N+1; earliest data_ok is N+2.
  - The next grant can be made in the cycle after data_ok.
- Simultaneous events:
  - m_data_ok in the same cycle as flush, owner = inst: the response is dropped.
  - A new request in the same cycle as data_ok waits until IDLE.
- i_rdata and d_rdata mirror m_rdata at all times; they are valid only with their data_ok.
- Asserting rst mid-transaction returns to IDLE immediately. The memory side is reset by the same rst.

Decomposition:
- Shared package/header: state encodings, the SIZE_BYTE/HALF/WORD constants and the owner encoding.
- No sub-module; single module.

Test Plan:
- i_req = 1, addr = 0x1C000000; m_addr_ok the same cycle it is seen; m_data_ok next cycle with 0x02800000 -> i_addr_ok at N+1, i_data_ok at N+2, i_rdata = 0x02800000, d_* quiet.
- d_req write, addr = 0x8000, wdata = 0xDEADBEEF, wstrb = 0xF, size = 2 -> m_wr = 1 with identical payload; d_data_ok pulses once on m_data_ok.
- i_req and d_req both high continuously for 4 transactions, last_grant = 0 after reset -> grant order data, inst, data, inst.
- Inst owner in DATA, flush pulse, then m_data_ok = 1, m_rdata = 0x1234 -> i_data_ok stays 0; next i_req at new_pc is served normally.
- Inst owner in ADDR with m_addr_ok held low 3 cycles; flush in cycle 1 -> m_req stays 1 until m_addr_ok, i_addr_ok never pulses, response is dropped.
- rst asserted while in DATA -> next edge all outputs 0, state IDLE; a post-reset i_req completes normally.
